mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the instruction-fetch requester (if_*) and the load/store requester (dm_*) of the RISC-V core. It accepts one access at a time, drives the memory for one cycle, waits a fixed memory latency, then returns a registered response to the owner. Data accesses have priority, and a streak limit keeps fetch from starving. It sits between the core's fetch/LSU logic and the unified memory macro.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_lat_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;
    localparam int         CNT_W     = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the memory latency; o_last marks the final wait cycle.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// one access at a time, with data priority bounded by a fetch-starvation streak limit.
//
// state  | meaning
// IDLE   | waiting for a request; gnt is decided combinationally here
// ACCESS | memory strobe cycle driven from the latched request
// WAIT   | counting down the memory latency; last cycle captures read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    input  logic              i_dm_req,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic              i_dm_we,
    input  logic [DATA_W-1:0] i_dm_wdata,
    input  logic [2:0]        i_dm_size,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_busy,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [2:0]        o_mem_size,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_CONSEC);

    state_t            r_state;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_size;
    logic [CNT_W-1:0]  r_streak;
    logic              r_mem_en;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic              w_last;
    logic              w_cnt_load;
    logic              w_cnt_dec;

    // Fetch only wins a contested cycle once data has used up its streak.
    assign w_if_gnt = (r_state == IDLE) && i_if_req && (!i_dm_req || (r_streak == STREAK_MAX));
    assign w_dm_gnt = (r_state == IDLE) && i_dm_req && !w_if_gnt;

    assign w_cnt_load = (r_state == ACCESS);
    assign w_cnt_dec  = (r_state == WAIT);

    mem_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_streak    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_if_gnt) begin
                        r_owner  <= OWN_IF;
                        r_addr   <= i_if_addr;
                        r_size   <= SIZE_WORD;
                        r_streak <= '0;
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ACCESS;
                    end else if (w_dm_gnt) begin
                        r_owner  <= OWN_DM;
                        r_addr   <= i_dm_addr;
                        r_wdata  <= i_dm_wdata;
                        r_size   <= i_dm_size;
                        r_mem_en <= 1'b1;
                        r_mem_we <= i_dm_we;
                        r_busy   <= 1'b1;
                        r_state  <= ACCESS;
                        if (!i_if_req) begin
                            r_streak <= '0;
                        end else if (r_streak != STREAK_MAX) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_last) begin
                        r_rdata     <= i_mem_rdata;
                        r_if_rvalid <= (r_owner == OWN_IF);
                        r_dm_rvalid <= (r_owner == OWN_DM);
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_dm_gnt    = w_dm_gnt;
    assign o_if_rvalid = r_if_rvalid;
    assign o_dm_rvalid = r_dm_rvalid;
    assign o_rsp_rdata = r_rdata;
    assign o_busy      = r_busy;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_size  = r_size;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: DUT A has MEM_LAT=1/MAX_CONSEC=4, DUT B has MEM_LAT=3/MAX_CONSEC=1.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic        a_if_req = 1'b0, a_dm_req = 1'b0, a_dm_we = 1'b0;
    logic [11:0] a_if_addr = '0, a_dm_addr = '0;
    logic [31:0] a_dm_wdata = '0;
    logic [2:0]  a_dm_size = '0;
    logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_busy, a_mem_en, a_mem_we;
    logic [31:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
    logic [11:0] a_mem_addr;
    logic [2:0]  a_mem_size;

    logic        b_if_req = 1'b0, b_dm_req = 1'b0, b_dm_we = 1'b0;
    logic [11:0] b_if_addr = '0, b_dm_addr = '0;
    logic [31:0] b_dm_wdata = '0;
    logic [2:0]  b_dm_size = '0;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_busy, b_mem_en, b_mem_we;
    logic [31:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic [11:0] b_mem_addr;
    logic [2:0]  b_mem_size;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(1), .MAX_CONSEC(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_if_req(a_if_req), .i_if_addr(a_if_addr), .o_if_gnt(a_if_gnt), .o_if_rvalid(a_if_rvalid),
        .i_dm_req(a_dm_req), .i_dm_addr(a_dm_addr), .i_dm_we(a_dm_we), .i_dm_wdata(a_dm_wdata),
        .i_dm_size(a_dm_size), .o_dm_gnt(a_dm_gnt), .o_dm_rvalid(a_dm_rvalid),
        .o_rsp_rdata(a_rsp_rdata), .o_busy(a_busy), .o_mem_en(a_mem_en), .o_mem_we(a_mem_we),
        .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .o_mem_size(a_mem_size),
        .i_mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(3), .MAX_CONSEC(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_gnt(b_if_gnt), .o_if_rvalid(b_if_rvalid),
        .i_dm_req(b_dm_req), .i_dm_addr(b_dm_addr), .i_dm_we(b_dm_we), .i_dm_wdata(b_dm_wdata),
        .i_dm_size(b_dm_size), .o_dm_gnt(b_dm_gnt), .o_dm_rvalid(b_dm_rvalid),
        .o_rsp_rdata(b_rsp_rdata), .o_busy(b_busy), .o_mem_en(b_mem_en), .o_mem_we(b_mem_we),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .o_mem_size(b_mem_size),
        .i_mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [11:0] addr);
        return (addr == 12'h010) ? 32'hDEADBEEF : {20'hF00D0, addr};
    endfunction

    // Memory models: data is valid only exactly MEM_LAT cycles after mem_en, garbage otherwise.
    logic        a_pv = 1'b0;
    logic [11:0] a_pa = '0;
    always @(posedge clk) begin
        a_pv <= a_mem_en;
        a_pa <= a_mem_addr;
    end
    assign a_mem_rdata = a_pv ? mem_word(a_pa) : 32'hA5A5A5A5;

    logic [2:0]  b_pv = '0;
    logic [11:0] b_pa0 = '0, b_pa1 = '0, b_pa2 = '0;
    always @(posedge clk) begin
        b_pv  <= {b_pv[1:0], b_mem_en};
        b_pa0 <= b_mem_addr;
        b_pa1 <= b_pa0;
        b_pa2 <= b_pa1;
    end
    assign b_mem_rdata = b_pv[2] ? mem_word(b_pa2) : 32'h5A5A5A5A;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_busy, a_mem_en, a_mem_we,
             a_mem_addr, a_mem_wdata, a_mem_size, a_rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs got=%0h exp=0", {a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid,
                     a_busy, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_size, a_rsp_rdata});
        end
        checks++;
        if ({b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_busy, b_mem_en, b_mem_we,
             b_mem_addr, b_mem_wdata, b_mem_size, b_rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs got=%0h exp=0", {b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid,
                     b_busy, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_size, b_rsp_rdata});
        end
        tick;
        rst = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_fetch;
        a_if_req = 1'b1; a_if_addr = 12'h010; #1;
        checks++;
        if ({a_if_gnt, a_dm_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt got=%b exp=10", {a_if_gnt, a_dm_gnt});
        end
        tick; a_if_req = 1'b0; #1;
        checks++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_size, a_busy} !== {2'b10, 12'h010, 3'b010, 1'b1}) begin
            errors++; $display("FAIL fetch_access got=%0h exp=%0h",
                {a_mem_en, a_mem_we, a_mem_addr, a_mem_size, a_busy}, {2'b10, 12'h010, 3'b010, 1'b1});
        end
        tick;
        checks++;
        if ({a_mem_en, a_if_rvalid, a_busy} !== 3'b001) begin
            errors++; $display("FAIL fetch_wait got=%b exp=001", {a_mem_en, a_if_rvalid, a_busy});
        end
        tick;
        checks++;
        if ({a_if_rvalid, a_dm_rvalid, a_busy} !== 3'b100 || a_rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_rsp flags=%b rdata=%h exp flags=100 rdata=deadbeef",
                {a_if_rvalid, a_dm_rvalid, a_busy}, a_rsp_rdata);
        end
        tick;
        checks++;
        if (a_if_rvalid !== 1'b0 || a_rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_pulse rvalid=%b rdata=%h exp 0/deadbeef", a_if_rvalid, a_rsp_rdata);
        end
    endtask

    task automatic test_store;
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 12'h020; a_dm_wdata = 32'h12345678; a_dm_size = 3'b010; #1;
        checks++;
        if ({a_if_gnt, a_dm_gnt} !== 2'b01) begin
            errors++; $display("FAIL store_gnt got=%b exp=01", {a_if_gnt, a_dm_gnt});
        end
        tick; a_dm_req = 1'b0; a_dm_we = 1'b0; #1;
        checks++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_size} !==
            {2'b11, 12'h020, 32'h12345678, 3'b010}) begin
            errors++; $display("FAIL store_access got=%0h exp=%0h",
                {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_size}, {2'b11, 12'h020, 32'h12345678, 3'b010});
        end
        tick;
        checks++;
        if ({a_mem_en, a_mem_we} !== 2'b00 || a_mem_wdata !== 32'h12345678) begin
            errors++; $display("FAIL store_hold en_we=%b wdata=%h exp 00/12345678", {a_mem_en, a_mem_we}, a_mem_wdata);
        end
        tick;
        checks++;
        if ({a_if_rvalid, a_dm_rvalid} !== 2'b01) begin
            errors++; $display("FAIL store_rvalid got=%b exp=01", {a_if_rvalid, a_dm_rvalid});
        end
        tick;
    endtask

    task automatic test_streak;
        logic exp_if;
        logic prev_if;
        prev_if = 1'b0;
        a_if_addr = 12'h200; a_dm_addr = 12'h100; a_dm_size = 3'b000; a_dm_we = 1'b0;
        a_if_req = 1'b1; a_dm_req = 1'b1; #1;
        for (int g = 0; g < 10; g++) begin
            exp_if = ((g % 5) == 4);
            checks++;
            if ({a_if_gnt, a_dm_gnt} !== {exp_if, ~exp_if}) begin
                errors++; $display("FAIL streak_gnt%0d got=%b exp=%b", g, {a_if_gnt, a_dm_gnt}, {exp_if, ~exp_if});
            end
            if (g > 0) begin
                checks++;
                if ({a_if_rvalid, a_dm_rvalid} !== {prev_if, ~prev_if}) begin
                    errors++; $display("FAIL streak_rvalid%0d got=%b exp=%b", g,
                        {a_if_rvalid, a_dm_rvalid}, {prev_if, ~prev_if});
                end
            end
            tick;
            if (g == 9) begin
                a_if_req = 1'b0; a_dm_req = 1'b0;
            end
            #1;
            checks++;
            if ({a_mem_en, a_mem_addr, a_mem_size, a_if_gnt, a_dm_gnt} !==
                {1'b1, exp_if ? 12'h200 : 12'h100, exp_if ? 3'b010 : 3'b000, 2'b00}) begin
                errors++; $display("FAIL streak_access%0d got=%0h exp=%0h", g,
                    {a_mem_en, a_mem_addr, a_mem_size, a_if_gnt, a_dm_gnt},
                    {1'b1, exp_if ? 12'h200 : 12'h100, exp_if ? 3'b010 : 3'b000, 2'b00});
            end
            tick;
            checks++;
            if ({a_if_gnt, a_dm_gnt} !== 2'b00) begin
                errors++; $display("FAIL streak_nogrant%0d got=%b exp=00", g, {a_if_gnt, a_dm_gnt});
            end
            tick;
            prev_if = exp_if;
        end
        checks++;
        if ({a_if_rvalid, a_dm_rvalid} !== 2'b10 || a_rsp_rdata !== mem_word(12'h200)) begin
            errors++; $display("FAIL streak_last flags=%b rdata=%h exp 10/%h",
                {a_if_rvalid, a_dm_rvalid}, a_rsp_rdata, mem_word(12'h200));
        end
        tick;
    endtask

    task automatic test_long_latency;
        int n;
        b_if_addr = 12'h0C4; b_dm_addr = 12'h030; b_dm_we = 1'b0; b_dm_size = 3'b010;
        b_if_req = 1'b1; b_dm_req = 1'b1; #1;
        checks++;
        if ({b_if_gnt, b_dm_gnt} !== 2'b01) begin
            errors++; $display("FAIL lat_gnt0 got=%b exp=01", {b_if_gnt, b_dm_gnt});
        end
        tick; b_dm_req = 1'b0; #1;
        checks++;
        if ({b_mem_en, b_mem_addr, b_if_gnt, b_dm_gnt} !== {1'b1, 12'h030, 2'b00}) begin
            errors++; $display("FAIL lat_access got=%0h exp=%0h",
                {b_mem_en, b_mem_addr, b_if_gnt, b_dm_gnt}, {1'b1, 12'h030, 2'b00});
        end
        for (int c = 2; c <= 4; c++) begin
            tick;
            checks++;
            if ({b_mem_en, b_if_gnt, b_dm_gnt, b_dm_rvalid, b_busy} !== 5'b00001) begin
                errors++; $display("FAIL lat_wait_c%0d got=%b exp=00001", c,
                    {b_mem_en, b_if_gnt, b_dm_gnt, b_dm_rvalid, b_busy});
            end
        end
        tick;
        checks++;
        if ({b_dm_rvalid, b_if_gnt, b_dm_gnt} !== 3'b110 || b_rsp_rdata !== mem_word(12'h030)) begin
            errors++; $display("FAIL lat_rsp_c5 flags=%b rdata=%h exp 110/%h",
                {b_dm_rvalid, b_if_gnt, b_dm_gnt}, b_rsp_rdata, mem_word(12'h030));
        end
        tick; b_if_req = 1'b0; #1;
        checks++;
        if ({b_mem_en, b_mem_addr, b_mem_size} !== {1'b1, 12'h0C4, 3'b010}) begin
            errors++; $display("FAIL lat_if_access got=%0h exp=%0h",
                {b_mem_en, b_mem_addr, b_mem_size}, {1'b1, 12'h0C4, 3'b010});
        end
        n = 0;
        while (b_if_rvalid !== 1'b1 && n < 12) begin
            tick;
            n++;
        end
        checks++;
        if (n != 4 || b_rsp_rdata !== mem_word(12'h0C4)) begin
            errors++; $display("FAIL lat_if_rsp cycles=%0d rdata=%h exp 4/%h", n, b_rsp_rdata, mem_word(12'h0C4));
        end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        b_dm_addr = 12'h034; b_if_req = 1'b1; b_dm_req = 1'b1; #1;
        checks++;
        if ({b_if_gnt, b_dm_gnt} !== 2'b01) begin
            errors++; $display("FAIL rstmid_gnt got=%b exp=01", {b_if_gnt, b_dm_gnt});
        end
        tick; b_if_req = 1'b0; b_dm_req = 1'b0;
        tick;
        rst = 1'b1; #1;
        checks++;
        if ({b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_busy, b_mem_en, b_mem_we,
             b_mem_addr, b_mem_wdata, b_mem_size, b_rsp_rdata} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got=%0h exp=0", {b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid,
                b_busy, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_size, b_rsp_rdata});
        end
        tick;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if ({b_if_rvalid, b_dm_rvalid, b_busy, b_mem_en} !== 4'b0000) begin
                errors++; $display("FAIL rstmid_quiet%0d got=%b exp=0000", c,
                    {b_if_rvalid, b_dm_rvalid, b_busy, b_mem_en});
            end
        end
        b_if_req = 1'b1; b_dm_req = 1'b1; #1;
        checks++;
        if ({b_if_gnt, b_dm_gnt} !== 2'b01) begin
            errors++; $display("FAIL rstmid_streak_cleared got=%b exp=01", {b_if_gnt, b_dm_gnt});
        end
        tick; b_if_req = 1'b0; b_dm_req = 1'b0;
        for (int c = 0; c < 5; c++) tick;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            tick;
            checks++;
            if ({a_busy, a_mem_en, a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid} !== 6'b0) begin
                errors++; $display("FAIL idle_c%0d got=%b exp=000000", c,
                    {a_busy, a_mem_en, a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid});
            end
        end
        tick;
        a_if_req = 1'b1; a_if_addr = 12'h044; #1;
        checks++;
        if ({a_if_gnt, a_dm_gnt} !== 2'b10) begin
            errors++; $display("FAIL idle_resume_gnt got=%b exp=10", {a_if_gnt, a_dm_gnt});
        end
        tick; a_if_req = 1'b0; #1;
        checks++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 12'h044}) begin
            errors++; $display("FAIL idle_resume_access got=%0h exp=%0h", {a_mem_en, a_mem_addr}, {1'b1, 12'h044});
        end
        tick;
        tick;
        checks++;
        if (a_if_rvalid !== 1'b1 || a_rsp_rdata !== mem_word(12'h044)) begin
            errors++; $display("FAIL idle_resume_rsp rvalid=%b rdata=%h exp 1/%h",
                a_if_rvalid, a_rsp_rdata, mem_word(12'h044));
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store;
        test_streak;
        test_long_latency;
        test_reset_mid_wait;
        test_idle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1);
    end

endmodule
